// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and helpers for muldiv_unit
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADJ  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] op_i);
    return op_i[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] part_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              div_mode_i,
  output logic [2*XLEN-1:0] part_o,
  output logic              qbit_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    add_sum = {1'b0, part_i[2*XLEN-1:XLEN]} + (part_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh  = {part_i[2*XLEN-1:XLEN], part_i[XLEN-1]};
    // rem_sh < 2*divisor always, so the top bit of diff is a clean borrow flag
    diff    = rem_sh - {1'b0, opnd_i};
    qbit_o  = 1'b0;
    part_o  = {add_sum, part_i[XLEN-1:1]};
    if (div_mode_i) begin
      qbit_o = ~diff[XLEN];
      part_o = {(qbit_o ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), part_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV M-extension multiply/divide unit; MULDIV_FAST_MUL_EN enables single-cycle multiply
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic              in_ready_q, out_valid_q, busy_q;
  logic [XLEN-1:0]   result_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] part_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2:0]        op_q;
  logic              div_mode_q, sign_diff_q, a_neg_q;

  logic              div_op, sa, sb, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, adj_res, q_fix, r_fix;
  logic [2*XLEN-1:0] prod_fix, step_part;
  logic              step_qbit;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .part_i     (part_q),
    .opnd_i     (opnd_q),
    .div_mode_i (div_mode_q),
    .part_o     (step_part),
    .qbit_o     (step_qbit)
  );

  always_comb begin
    div_op = is_div(op);
    sa     = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    sb     = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg  = sa & a[XLEN-1];
    b_neg  = sb & b[XLEN-1];
    abs_a  = a_neg ? -a : a;
    abs_b  = b_neg ? -b : b;
    b_zero = (b == '0);
    ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
    // op[1] separates REM/REMU from DIV/DIVU
    if (b_zero) special_res = op[1] ? a : '1;
    else        special_res = op[1] ? '0 : a;
  end

  always_comb begin
    prod_fix = sign_diff_q ? -part_q : part_q;
    q_fix    = sign_diff_q ? -part_q[XLEN-1:0] : part_q[XLEN-1:0];
    r_fix    = a_neg_q ? -part_q[2*XLEN-1:XLEN] : part_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       adj_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: adj_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              adj_res = q_fix;
      default:                      adj_res = r_fix;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    a_ext     = {{XLEN{a_neg}}, a};
    b_ext     = {{XLEN{b_neg}}, b};
    fast_prod = a_ext * b_ext;
    fast_res  = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      cnt_q       <= '0;
      part_q      <= '0;
      opnd_q      <= '0;
      op_q        <= OP_MUL;
      div_mode_q  <= 1'b0;
      sign_diff_q <= 1'b0;
      a_neg_q     <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q        <= op;
            div_mode_q  <= div_op;
            sign_diff_q <= a_neg ^ b_neg;
            a_neg_q     <= a_neg;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            if (div_op && (b_zero || ovf)) begin
              result_q    <= special_res;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!div_op) begin
              result_q    <= fast_res;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
`endif
            else begin
              part_q  <= {{XLEN{1'b0}}, abs_a};
              opnd_q  <= abs_b;
              cnt_q   <= CNT_W'(XLEN);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          // step leaves bit 0 clear in divide mode; the quotient bit is merged here
          part_q <= {step_part[2*XLEN-1:1], step_part[0] | step_qbit};
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ADJ;
        end
        ADJ: begin
          result_q    <= adj_res;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, busy;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t dv [0:13];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    logic [31:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = '0;
    case (o)
      OP_MUL:    begin p = ux * uy;            r = p[31:0];  end
      OP_MULH:   begin p = sx * sy;            r = p[63:32]; end
      OP_MULHSU: begin p = sx * longint'(uy);  r = p[63:32]; end
      OP_MULHU:  begin p = ux * uy;            r = p[63:32]; end
      OP_DIV: begin
        if (y == 0) r = 32'hFFFFFFFF;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
        else begin p = sx / sy; r = p[31:0]; end
      end
      OP_DIVU: begin
        if (y == 0) r = 32'hFFFFFFFF;
        else begin p = ux / uy; r = p[31:0]; end
      end
      OP_REM: begin
        if (y == 0) r = x;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h0;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: begin
        if (y == 0) r = x;
        else begin p = ux % uy; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[2]) return MUL_LAT;
    if (y == 0) return 1;
    if ((o == OP_DIV || o == OP_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
    return DIV_LAT;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 32'h00000000;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h00000001;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a negedge; returns at the negedge where out_valid is first seen.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] res);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3;
    repeat (3) @(negedge clk);
    n_total++;
    if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b res=%h want 1 0 0 00000000",
               in_ready, out_valid, busy, result);
    else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_directed();
    int          lat;
    logic [31:0] res;
    dv[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
    dv[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
    dv[2]  = '{OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
    dv[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT};
    dv[4]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT};
    dv[5]  = '{OP_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT};
    dv[6]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT};
    dv[7]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT};
    dv[8]  = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
    dv[9]  = '{OP_REM,    32'd5,        32'd0,        32'd5,        1};
    dv[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    dv[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
    dv[12] = '{OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h0,        DIV_LAT};
    dv[13] = '{OP_REMU,   32'd5,        32'd0,        32'd5,        1};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      issue(dv[i].op, dv[i].a, dv[i].b, lat, res);
      n_total++;
      if (res !== dv[i].exp)
        $display("FAIL directed_result[%0d] op=%0d a=%h b=%h got %h want %h", i, dv[i].op, dv[i].a, dv[i].b, res, dv[i].exp);
      else n_pass++;
      n_total++;
      if (lat != dv[i].lat)
        $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, dv[i].lat);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [31:0] res, x, y;
    logic [2:0]  o;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick_operand();
      y = pick_operand();
      @(negedge clk);
      issue(o, x, y, lat, res);
      n_total++;
      if (res !== ref_model(o, x, y))
        $display("FAIL random_result[%0d] op=%0d a=%h b=%h got %h want %h", i, o, x, y, res, ref_model(o, x, y));
      else n_pass++;
      n_total++;
      if (lat != ref_latency(o, x, y))
        $display("FAIL random_latency[%0d] op=%0d got %0d want %0d", i, o, lat, ref_latency(o, x, y));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [31:0] res, x, y;
    logic [2:0]  o;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      issue(o, x, y, lat, res);
      n_total++;
      if (res !== ref_model(o, x, y))
        $display("FAIL b2b_result[%0d] op=%0d got %h want %h", i, o, res, ref_model(o, x, y));
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({in_ready, out_valid, busy} !== 3'b100)
        $display("FAIL b2b_idle[%0d] got rdy/vld/busy=%b%b%b want 100", i, in_ready, out_valid, busy);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] res;
    out_ready = 1'b0;
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7, lat, res);
    n_total++;
    if (lat != DIV_LAT) $display("FAIL bp_latency got %0d want %0d", lat, DIV_LAT);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if ({out_valid, in_ready, busy, result} !== {1'b1, 1'b0, 1'b1, 32'd14})
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b busy=%b res=%h want 1 0 1 0000000e",
                 i, out_valid, in_ready, busy, result);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({out_valid, in_ready, busy} !== 3'b010)
      $display("FAIL bp_release got vld/rdy/busy=%b%b%b want 010", out_valid, in_ready, busy);
    else n_pass++;
  endtask

  // Abort a DIV at k+10 via flush (use_rst=0) or reset (use_rst=1), then run DIVU 9/3.
  task automatic test_abort(input logic use_rst);
    int          lat;
    logic [31:0] res, prev, want_res;
    logic        seen_valid;
    seen_valid = 1'b0;
    @(negedge clk);
    prev = result;
    want_res = use_rst ? 32'h0 : prev;
    op = OP_DIV; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      seen_valid |= out_valid;
      @(negedge clk);
    end
    n_total++;
    if (busy !== 1'b1) $display("FAIL abort_busy_before got %b want 1", busy);
    else n_pass++;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    n_total++;
    if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, want_res})
      $display("FAIL abort_after rst=%b got rdy=%b vld=%b busy=%b res=%h want 1 0 0 %h",
               use_rst, in_ready, out_valid, busy, result, want_res);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      seen_valid |= out_valid;
      @(negedge clk);
    end
    n_total++;
    if (seen_valid !== 1'b0) $display("FAIL abort_no_output rst=%b got out_valid=1 want never", use_rst);
    else n_pass++;
    issue(OP_DIVU, 32'd9, 32'd3, lat, res);
    n_total++;
    if (res !== 32'd3 || lat != DIV_LAT)
      $display("FAIL abort_followup rst=%b got res=%h lat=%0d want 00000003 lat=%0d", use_rst, res, lat, DIV_LAT);
    else n_pass++;
  endtask

  task automatic test_flush_idle();
    logic seen_valid;
    seen_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    op = OP_DIVU; a = 32'd9; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    n_total++;
    if ({in_ready, busy} !== 2'b10) $display("FAIL flush_idle_state got rdy/busy=%b%b want 10", in_ready, busy);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      seen_valid |= out_valid;
      @(negedge clk);
    end
    n_total++;
    if (seen_valid !== 1'b0) $display("FAIL flush_idle_dropped got out_valid=1 want never");
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_MUL; a = '0; b = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit; sequential companion to the single-cycle ALU.
- Implements the RV32M/RV64M op set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at width XLEN.
- Sits beside the ALU in the execute stage.
- Valid/ready handshake on both sides; the pipeline stalls while the unit is busy.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock
- rst, input, 1, synchronous active-high reset
- flush, input, 1, abort any in-flight op; no result produced
- in_valid, input, 1, request valid
- in_ready, output, 1, unit can accept a request (high only in IDLE)
- op, input, 3, funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a, input, XLEN, operand rs1
- b, input, XLEN, operand rs2
- out_valid, output, 1, result valid
- out_ready, input, 1, consumer takes result
- result, output, XLEN, op result
- busy, output, 1, state != IDLE

Behaviour:
- Reset values (synchronous, active-high, dominates all other inputs):
  - state = IDLE, in_ready = 1, out_valid = 0, result = 0, busy = 0
  - counter and internal registers = 0
- Accept: in_valid && in_ready at edge k.
  - Latch op, a, b.
  - Latch operand signs per op: MULH/DIV/REM treat both signed; MULHSU treats a signed, b unsigned.
  - Latch absolute values into the working registers.
- FSM states: IDLE -> CALC -> ADJ -> DONE -> IDLE.
- CALC, cycles k+1..k+XLEN, one iteration per cycle, counter counts XLEN down to 0:
  - Multiply: shift-add on a 2·XLEN product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
- ADJ, cycle k+XLEN+1:
  - Apply sign correction; product negated if signs differ.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - Select low half (MUL), high half (MULH*), quotient or remainder.
- DONE, from k+XLEN+2:
  - out_valid = 1; result held stable until out_ready.
  - out_valid && out_ready -> IDLE next cycle.
  - A new request can be accepted no earlier than the cycle after return to IDLE; there is no overlap.
- Special cases, resolved at accept and going straight to DONE at k+1:
  - Divide by zero (b == 0): DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a == most-negative, b == −1, DIV/REM only): DIV gives a; REM gives 0.
- Backpressure: while in DONE with out_ready low, result, out_valid and in_ready = 0 are all held indefinitely.
- Flush: in any state -> IDLE next cycle, out_valid = 0, result unchanged, no output produced. Flush in IDLE coincident with in_valid drops the request (in_ready still reads 1; the requester must not count it as accepted).
- Reset mid-operation: abort immediately; all outputs take reset values at the next edge.
- Width rules:
  - All arithmetic is modulo 2^XLEN except the internal 2·XLEN product.
  - Absolute value of most-negative is handled as the unsigned magnitude; no overflow inside CALC.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL* ops compute a full signed/unsigned 2·XLEN product combinationally at accept, register it, and enter DONE at k+1. Divide path is unchanged.
- Undefined: all MUL* ops take the iterative path (out_valid at k+XLEN+2). No multiplier inferred.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding localparams (OP_MUL..OP_REMU)
  - FSM state typedef (IDLE, CALC, ADJ, DONE)
  - helper function is_div(op)
- Sub-module muldiv_step: combinational single iteration, shared by multiply and divide.
  - Inputs: partial register, operand, mode.
  - Outputs: next partial, quotient bit.
  - Instantiated once in muldiv_unit.

Test Plan:
- XLEN=32, MUL a=7 b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 34 cycles after accept (0 with macro: 1 cycle).
- MULH a=0x80000000 b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14, REMU 100/7 -> 2; DIV −7/2 -> 0xFFFFFFFD, REM −7/2 -> 0xFFFFFFFF.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both at k+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, busy=1; out_ready=1 -> IDLE next cycle.
- Flush at k+10 of DIV, and separately rst at k+10 -> out_valid never asserts, in_ready=1 next cycle; a following DIVU 9/3 returns 3 correctly.
